// File: rtl/i2c_sensor_poller.sv
// ---------------------------------------------------------------------------
// i2c_sensor_poller
//
// Round-robin poller for I2C temperature and light sensors. It walks a table
// of 7-bit slave addresses and issues a two-byte read to each enabled channel
// through a byte-level I2C master. Each result is converted by channel kind
// and published with valid and error flags. A programmable idle interval
// follows every sweep. A NACKed read is retried up to MAX_RETRY extra times
// before the channel is flagged as in error.
//
// Parameters:
//   NUM_CH      number of channels (1..16)
//   ADDR_TABLE  packed slave addresses, channel i at [7i+6:7i]
//   KIND_MASK   bit i = 1: channel i is lux, 0: temperature
//   POLL_DIV    idle cycles between sweeps (>= 1)
//   MAX_RETRY   extra attempts after a NACK
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   enable        run sweeps while high
//   ch_mask       per-channel poll enable
//   m_start       one-cycle transaction request to the master
//   m_addr        slave address, held from m_start until completion
//   m_rw          constant 1 (read)
//   m_two_bytes   constant 1
//   m_ready       master idle / transaction done
//   m_ack         slave acknowledged the last transaction
//   m_data        read data, MSB byte first
//   ch_value      converted value per channel, channel i at [16i+15:16i]
//   ch_valid      channel has had at least one successful read
//   ch_err        last attempt sequence on the channel ran out of retries
//   sweep_done    one-cycle pulse at the end of each sweep
//   busy          FSM is outside IDLE
// ---------------------------------------------------------------------------
module i2c_sensor_poller #(
    parameter int unsigned         NUM_CH     = 8,
    parameter logic [7*NUM_CH-1:0] ADDR_TABLE = {7'h47, 7'h46, 7'h45, 7'h44,
                                                 7'h4B, 7'h4A, 7'h49, 7'h48},
    parameter logic [NUM_CH-1:0]   KIND_MASK  = 8'hF0,
    parameter int unsigned         POLL_DIV   = 1000,
    parameter int unsigned         MAX_RETRY  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NUM_CH-1:0]      ch_mask,
    output logic                   m_start,
    output logic [6:0]             m_addr,
    output logic                   m_rw,
    output logic                   m_two_bytes,
    input  logic                   m_ready,
    input  logic                   m_ack,
    input  logic [15:0]            m_data,
    output logic [16*NUM_CH-1:0]   ch_value,
    output logic [NUM_CH-1:0]      ch_valid,
    output logic [NUM_CH-1:0]      ch_err,
    output logic                   sweep_done,
    output logic                   busy
);

    localparam int unsigned IdxW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CntW   = $clog2(POLL_DIV + 1);
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NUM_CH - 1);
    localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRY);
    localparam logic [CntW-1:0]   CntLoad  = CntW'(POLL_DIV);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StIssue,
        StWaitAccept,
        StWaitDone,
        StNext,
        StInterval
    } state_e;

    state_e            state;
    logic [IdxW-1:0]   idx;
    logic [RetryW-1:0] retry;
    logic [CntW-1:0]   cnt;

    // Per-index lookups of the channel tables.
    logic [6:0] sel_addr;
    logic       sel_en;
    logic       sel_lux;

    always_comb begin
        sel_addr = '0;
        sel_en   = 1'b0;
        sel_lux  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == IdxW'(i)) begin
                sel_addr = ADDR_TABLE[7*i +: 7];
                sel_en   = ch_mask[i];
                sel_lux  = KIND_MASK[i];
            end
        end
    end

    // Result conversion. Lux: 12-bit mantissa shifted by a 4-bit exponent,
    // scaled by 1/100; the widest shifted value needs 27 bits.
    logic [26:0] lux_scaled;
    logic [26:0] lux_q;
    logic [15:0] conv_value;

    always_comb begin
        lux_scaled = 27'(m_data[11:0]) << m_data[15:12];
        lux_q      = lux_scaled / 27'd100;
        if (sel_lux) begin
            conv_value = (lux_q > 27'h00_FFFF) ? 16'hFFFF : lux_q[15:0];
        end else begin
            conv_value = {{8{m_data[15]}}, m_data[15:8]};
        end
    end

    assign m_rw        = 1'b1;
    assign m_two_bytes = 1'b1;
    assign busy        = (state != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            idx        <= '0;
            retry      <= '0;
            cnt        <= '0;
            m_start    <= 1'b0;
            m_addr     <= '0;
            sweep_done <= 1'b0;
            ch_value   <= '0;
            ch_valid   <= '0;
            ch_err     <= '0;
        end else begin
            m_start    <= 1'b0;
            sweep_done <= 1'b0;

            case (state)
                StIdle: begin
                    if (enable && m_ready) begin
                        idx   <= '0;
                        retry <= '0;
                        state <= StSelect;
                    end
                end

                StSelect: begin
                    if (!enable) begin
                        state <= StIdle;
                    end else if (sel_en) begin
                        m_addr <= sel_addr;
                        state  <= StIssue;
                    end else begin
                        state <= StNext;
                    end
                end

                StIssue: begin
                    m_start <= 1'b1;
                    state   <= StWaitAccept;
                end

                // m_ready is still high while the request is in flight to the
                // master; only its drop marks acceptance.
                StWaitAccept: begin
                    if (!m_ready) begin
                        state <= StWaitDone;
                    end
                end

                StWaitDone: begin
                    if (m_ready) begin
                        if (m_ack) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (idx == IdxW'(i)) begin
                                    ch_value[16*i +: 16] <= conv_value;
                                    ch_valid[i]          <= 1'b1;
                                    ch_err[i]            <= 1'b0;
                                end
                            end
                            retry <= '0;
                            state <= enable ? StNext : StIdle;
                        end else if (retry < MaxRetry) begin
                            retry <= retry + 1'b1;
                            state <= StIssue;
                        end else begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (idx == IdxW'(i)) begin
                                    ch_err[i] <= 1'b1;
                                end
                            end
                            retry <= '0;
                            state <= enable ? StNext : StIdle;
                        end
                    end
                end

                StNext: begin
                    retry <= '0;
                    if (!enable) begin
                        state <= StIdle;
                    end else if (idx == LastIdx) begin
                        sweep_done <= 1'b1;
                        cnt        <= CntLoad;
                        state      <= StInterval;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= StSelect;
                    end
                end

                // Loaded with POLL_DIV, so the interval lasts exactly POLL_DIV
                // cycles before the next SELECT.
                StInterval: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CntW'(1)) begin
                        idx   <= '0;
                        state <= enable ? StSelect : StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_sensor_poller.sv
// ---------------------------------------------------------------------------
// tb_i2c_sensor_poller
//
// Bench for i2c_sensor_poller. A behavioural I2C master answers every request
// with randomised latency and either a queued or a random response, and keeps
// a channel-level reference model (value / valid / error per channel, retry
// bookkeeping) that a compare process checks against the DUT every cycle.
// Directed scenarios pin the model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_i2c_sensor_poller;

    localparam int NUM_CH    = 8;
    localparam int POLL_DIV  = 10;
    localparam int MAX_RETRY = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 enable = 1'b0;
    logic [NUM_CH-1:0]    ch_mask = '0;
    logic                 m_start;
    logic [6:0]           m_addr;
    logic                 m_rw;
    logic                 m_two_bytes;
    logic                 m_ready = 1'b1;
    logic                 m_ack = 1'b0;
    logic [15:0]          m_data = '0;
    logic [16*NUM_CH-1:0] ch_value;
    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH-1:0]    ch_err;
    logic                 sweep_done;
    logic                 busy;

    i2c_sensor_poller #(
        .NUM_CH     (NUM_CH),
        .ADDR_TABLE ({7'h47, 7'h46, 7'h45, 7'h44, 7'h4B, 7'h4A, 7'h49, 7'h48}),
        .KIND_MASK  (8'hF0),
        .POLL_DIV   (POLL_DIV),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .ch_mask     (ch_mask),
        .m_start     (m_start),
        .m_addr      (m_addr),
        .m_rw        (m_rw),
        .m_two_bytes (m_two_bytes),
        .m_ready     (m_ready),
        .m_ack       (m_ack),
        .m_data      (m_data),
        .ch_value    (ch_value),
        .ch_valid    (ch_valid),
        .ch_err      (ch_err),
        .sweep_done  (sweep_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Channel tables as the bench understands them.
    logic [6:0] addr_tab [NUM_CH] = '{7'h48, 7'h49, 7'h4A, 7'h4B,
                                      7'h44, 7'h45, 7'h46, 7'h47};
    logic [7:0] kind_mask = 8'hF0;

    // Reference model state.
    logic [15:0]       exp_val [NUM_CH];
    logic [NUM_CH-1:0] exp_valid;
    logic [NUM_CH-1:0] exp_err;
    int                attempts [NUM_CH];
    bit                retry_pending;
    int                last_ch;
    int                last_fresh;
    logic [7:0]        started_set;
    logic [7:0]        last_sweep_set;
    int                start_cnt = 0;

    logic [16:0] resp_q [$];
    bit          drop_req = 1'b0;
    bit          rst_req  = 1'b0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    function automatic logic [15:0] model_conv(input int ch, input logic [15:0] d);
        longint lux;
        int     t;
        int     e;
        if (kind_mask[ch]) begin
            e   = int'(d[15:12]);
            lux = longint'(d[11:0]);
            for (int k = 0; k < e; k++) lux = lux * 2;
            lux = lux / 100;
            if (lux > 65535) lux = 65535;
            return lux[15:0];
        end
        t = int'(d[15:8]);
        if (t > 127) t = t - 256;
        return t[15:0];
    endfunction

    function automatic int find_ch(input logic [6:0] a);
        int r = -1;
        for (int i = 0; i < NUM_CH; i++) if (addr_tab[i] == a) r = i;
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NUM_CH; i++) begin
            exp_val[i]  = '0;
            attempts[i] = 0;
        end
        exp_valid     = '0;
        exp_err       = '0;
        retry_pending = 1'b0;
        last_ch       = 0;
        last_fresh    = -1;
        started_set   = '0;
    endtask

    task automatic apply(input int ch, input logic [16:0] r);
        if (r[16]) begin
            exp_val[ch]   = model_conv(ch, r[15:0]);
            exp_valid[ch] = 1'b1;
            exp_err[ch]   = 1'b0;
            attempts[ch]  = 0;
            retry_pending = 1'b0;
        end else begin
            attempts[ch]++;
            if (attempts[ch] > MAX_RETRY) begin
                exp_err[ch]   = 1'b1;
                attempts[ch]  = 0;
                retry_pending = 1'b0;
            end else begin
                retry_pending = 1'b1;
            end
        end
    endtask

    // Behavioural master; acts 1 ns after each rising edge.
    int          mst = 0;
    int          acc_wait = 0;
    int          busy_cnt = 0;
    int          cur_ch = 0;
    logic [6:0]  cur_addr = '0;
    logic [16:0] resp = '0;

    initial begin
        clear_model();
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mst     = 0;
                m_ready = 1'b1;
                continue;
            end
            if (!busy) begin
                last_fresh  = -1;
                started_set = '0;
            end
            if (sweep_done) begin
                check("sweep_channel_set", started_set, ch_mask);
                last_sweep_set = started_set;
                started_set    = '0;
                last_fresh     = -1;
            end
            case (mst)
                0: begin
                    if (m_start) begin
                        cur_addr = m_addr;
                        cur_ch   = find_ch(m_addr);
                        start_cnt++;
                        check("addr_in_table", cur_ch >= 0, 1);
                        if (cur_ch < 0) cur_ch = 0;
                        if (retry_pending) begin
                            check("retry_same_ch", cur_ch, last_ch);
                        end else begin
                            check("fresh_order", cur_ch > last_fresh, 1);
                            check("fresh_masked", ch_mask[cur_ch], 1);
                            last_fresh = cur_ch;
                        end
                        last_ch             = cur_ch;
                        started_set[cur_ch] = 1'b1;
                        acc_wait            = $urandom_range(0, 2);
                        if (acc_wait == 0) begin
                            m_ready  = 1'b0;
                            busy_cnt = $urandom_range(1, 4);
                            mst      = 2;
                        end else begin
                            mst = 1;
                        end
                    end
                end
                1: begin
                    check("addr_stable", m_addr, cur_addr);
                    acc_wait--;
                    if (acc_wait == 0) begin
                        m_ready  = 1'b0;
                        busy_cnt = $urandom_range(1, 4);
                        mst      = 2;
                    end
                end
                2: begin
                    check("addr_stable", m_addr, cur_addr);
                    if (drop_req) begin
                        enable   = 1'b0;
                        drop_req = 1'b0;
                    end
                    if (rst_req) begin
                        rst     = 1'b1;
                        rst_req = 1'b0;
                        clear_model();
                        m_ready = 1'b1;
                        mst     = 0;
                    end else begin
                        busy_cnt--;
                        if (busy_cnt == 0) begin
                            if (resp_q.size() > 0) resp = resp_q.pop_front();
                            else resp = {($urandom_range(0, 9) < 7), 16'($urandom)};
                            m_ack   = resp[16];
                            m_data  = resp[15:0];
                            m_ready = 1'b1;
                            mst     = 3;
                        end
                    end
                end
                default: begin
                    // DUT sampled the completion on the edge just passed.
                    apply(cur_ch, resp);
                    m_ack  = 1'($urandom);
                    m_data = 16'($urandom);
                    mst    = 0;
                end
            endcase
        end
    end

    // Compare process: DUT outputs against the model on every falling edge.
    initial begin
        logic [16*NUM_CH-1:0] expv;
        logic                 prev_start = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) expv[16*i +: 16] = exp_val[i];
            check("ch_value", ch_value, expv);
            check("ch_flags", {ch_valid, ch_err}, {exp_valid, exp_err});
            check("const_outs", {m_rw, m_two_bytes}, 2'b11);
            if (m_start) check("start_width", prev_start, 1'b0);
            prev_start = m_start;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_sweep(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sweep_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("sweep_wait");
    endtask

    task automatic wait_idle(input int budget, output int sweeps);
        bit ok = 1'b0;
        sweeps = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sweep_done) sweeps++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("idle_wait");
    endtask

    task automatic wait_start(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("start_wait");
    endtask

    // One sweep from IDLE, stopping at the end of its interval.
    task automatic run_sweep(input logic [7:0] mask);
        bit ok;
        int sw;
        step();
        ch_mask = mask;
        enable  = 1'b1;
        wait_sweep(1000, ok);
        step();
        enable = 1'b0;
        wait_idle(200, sw);
    endtask

    initial begin
        bit     ok;
        int     sw;
        int     s0;
        longint t0;
        longint t1;

        // Reset state.
        repeat (3) step();
        @(negedge clk);
        check("rst_ch_value", ch_value, 0);
        check("rst_flags", {ch_valid, ch_err}, 0);
        check("rst_ctrl", {m_start, m_addr, sweep_done, busy}, 0);
        step();
        rst = 1'b0;
        repeat (2) step();

        // Temperature: 0xE7 = -25 C.
        resp_q.push_back({1'b1, 16'hE700});
        run_sweep(8'h01);
        check("temp_value", ch_value[15:0], 16'hFFE7);
        check("temp_flags", {ch_valid[0], ch_err[0]}, 2'b10);

        // Lux on channel 4.
        resp_q.push_back({1'b1, 16'h5ABC});
        run_sweep(8'h10);
        check("lux_5abc", ch_value[79:64], 16'd879);
        resp_q.push_back({1'b1, 16'hFFFF});
        run_sweep(8'h10);
        check("lux_sat", ch_value[79:64], 16'hFFFF);
        resp_q.push_back({1'b1, 16'h0063});
        run_sweep(8'h10);
        check("lux_zero", ch_value[79:64], 16'h0000);

        // Retry: two NACKs then ACK, then three NACKs.
        s0 = start_cnt;
        resp_q.push_back({1'b0, 16'h1234});
        resp_q.push_back({1'b0, 16'h5678});
        resp_q.push_back({1'b1, 16'h1900});
        run_sweep(8'h02);
        check("retry_starts", start_cnt - s0, 3);
        check("retry_value", ch_value[31:16], 16'h0019);
        check("retry_flags", {ch_valid[1], ch_err[1]}, 2'b10);
        s0 = start_cnt;
        repeat (3) resp_q.push_back({1'b0, 16'hAAAA});
        run_sweep(8'h02);
        check("exhaust_starts", start_cnt - s0, 3);
        check("exhaust_value", ch_value[31:16], 16'h0019);
        check("exhaust_flags", {ch_valid[1], ch_err[1]}, 2'b11);

        // Masking: only channels 0 (0x48) and 7 (0x47).
        run_sweep(8'h81);
        check("mask_81_set", last_sweep_set, 8'h81);

        // All-zero mask: period 2*NUM_CH + POLL_DIV, no requests.
        step();
        ch_mask = '0;
        enable  = 1'b1;
        s0      = start_cnt;
        wait_sweep(200, ok);
        t0 = $time;
        wait_sweep(200, ok);
        t1 = $time;
        check("zero_mask_period", (t1 - t0) / 10, 2 * NUM_CH + POLL_DIV);
        step();
        enable = 1'b0;
        wait_idle(200, sw);
        check("zero_mask_starts", start_cnt - s0, 0);

        // Interval: next request no sooner than POLL_DIV + 1 cycles.
        step();
        ch_mask = 8'h01;
        enable  = 1'b1;
        wait_sweep(400, ok);
        t0 = $time;
        wait_start(200);
        t1 = $time;
        check("interval_gap", ((t1 - t0) / 10) >= POLL_DIV + 1, 1);
        step();
        enable = 1'b0;
        wait_idle(400, sw);

        // Enable dropped in WAIT_DONE: read recorded, then IDLE, no sweep_done.
        step();
        ch_mask = 8'h04;
        resp_q.push_back({1'b1, 16'h3200});
        drop_req = 1'b1;
        enable   = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!drop_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("drop_wait");
        wait_idle(200, sw);
        check("drop_no_sweep", sw, 0);
        check("drop_busy", busy, 1'b0);
        check("drop_value", ch_value[47:32], 16'h0032);
        check("drop_valid", ch_valid[2], 1'b1);

        // Reset during WAIT_DONE.
        step();
        ch_mask = 8'hFF;
        rst_req = 1'b1;
        enable  = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rst) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("reset_wait");
        check("mid_rst_value", ch_value, 0);
        check("mid_rst_flags", {ch_valid, ch_err}, 0);
        check("mid_rst_ctrl", {m_start, m_addr, sweep_done, busy}, 0);
        step();
        enable = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        enable = 1'b1;
        wait_start(200);
        check("post_rst_first_addr", m_addr, 7'h48);

        // Randomised sweeps with a fresh mask each interval.
        for (int s = 0; s < 12; s++) begin
            wait_sweep(1500, ok);
            if (!ok) break;
            step();
            ch_mask = 8'($urandom);
        end
        step();
        enable = 1'b0;
        wait_idle(1500, sw);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
